// File: rtl/xgmii_link_monitor.sv
// XGMII receive link monitor: LF/RF fault-sequence detection, DOWN/HOLD/UP link FSM, error/drop statistics.
// Statistics counters exist only when XGMII_LINK_STATS_EN is defined; otherwise they read as constant 0.
module xgmii_link_monitor #(
    parameter int UP_CYCLES    = 1024,
    parameter int FAULT_WINDOW = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_ready,
    input  logic [71:0] xgmii_rx_dc,
    input  logic        stats_clear,
    output logic        link_up,
    output logic [1:0]  link_state,
    output logic        local_fault,
    output logic        remote_fault,
    output logic [15:0] err_count,
    output logic [15:0] drop_count
);

    localparam int GW = $clog2(FAULT_WINDOW + 1);
    localparam int UW = $clog2(UP_CYCLES + 1);
    localparam logic [GW-1:0] FW = GW'(FAULT_WINDOW);
    localparam logic [UW-1:0] UC = UW'(UP_CYCLES);
    localparam logic [71:0] IDLE_WORD = {8{9'h107}};

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_HOLD = 2'd1,
        ST_UP   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [71:0]     s1_dc_q;
    logic            s1_rdy_q;
    logic            seq_rf_q, seq_rf_d;
    logic [2:0]      seq_cnt_q, seq_cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            lf_q, lf_d, rf_q, rf_d;
    logic [UW-1:0]   good_q, good_d;
    logic            link_up_q;
    logic            drop_evt;
    logic [1:0]      col_a, col_b;
    logic            lf_cyc, rf_cyc, fault_cyc, err_cyc;

    // 0 = no sequence, 1 = local fault, 2 = remote fault
    function automatic logic [1:0] col_fault(input logic [35:0] c);
        logic [1:0] r;
        r = 2'd0;
        if (c[8:0] == 9'h19C && c[17:9] == 9'h000 && c[26:18] == 9'h000) begin
            if (c[35:27] == 9'h001)      r = 2'd1;
            else if (c[35:27] == 9'h002) r = 2'd2;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dc_q  <= IDLE_WORD;
            s1_rdy_q <= 1'b0;
        end else begin
            s1_dc_q  <= xgmii_rx_dc;
            s1_rdy_q <= rx_ready;
        end
    end

    assign col_a     = col_fault(s1_dc_q[35:0]);
    assign col_b     = col_fault(s1_dc_q[71:36]);
    assign lf_cyc    = (col_a == 2'd1) || (col_b == 2'd1);
    assign rf_cyc    = !lf_cyc && ((col_a == 2'd2) || (col_b == 2'd2));
    assign fault_cyc = lf_cyc || rf_cyc;

    always_comb begin
        err_cyc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (s1_dc_q[9*i +: 9] == 9'h1FE) err_cyc = 1'b1;
        end
    end

    // Fault detector; seq_rf records the type of the run being counted.
    always_comb begin
        seq_rf_d  = seq_rf_q;
        seq_cnt_d = seq_cnt_q;
        gap_d     = gap_q;
        lf_d      = lf_q;
        rf_d      = rf_q;
        if (fault_cyc) begin
            if ((rf_cyc == seq_rf_q) && (gap_q < FW)) begin
                if (seq_cnt_q != 3'd4) seq_cnt_d = seq_cnt_q + 3'd1;
            end else begin
                seq_rf_d  = rf_cyc;
                seq_cnt_d = 3'd1;
            end
            gap_d = '0;
            if (seq_cnt_d == 3'd4) begin
                lf_d = !seq_rf_d;
                rf_d = seq_rf_d;
            end
        end else if (gap_q != FW) begin
            gap_d = gap_q + GW'(1);
        end
        if (gap_d == FW) begin
            lf_d = 1'b0;
            rf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_rf_q  <= 1'b0;
            seq_cnt_q <= 3'd0;
            gap_q     <= FW;
            lf_q      <= 1'b0;
            rf_q      <= 1'b0;
        end else begin
            seq_rf_q  <= seq_rf_d;
            seq_cnt_q <= seq_cnt_d;
            gap_q     <= gap_d;
            lf_q      <= lf_d;
            rf_q      <= rf_d;
        end
    end

    // The FSM reacts to the fault flags as they update on this same edge.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        drop_evt = 1'b0;
        case (state_q)
            ST_DOWN: begin
                if (s1_rdy_q && !(lf_d || rf_d)) begin
                    state_d = ST_HOLD;
                    good_d  = '0;
                end
            end
            ST_HOLD: begin
                if (lf_d || rf_d || !s1_rdy_q) state_d = ST_DOWN;
                else if (err_cyc || fault_cyc)  good_d  = '0;
                else if (good_q == UC)          state_d = ST_UP;
                else                            good_d  = good_q + UW'(1);
            end
            ST_UP: begin
                if (lf_d || rf_d || !s1_rdy_q) begin
                    state_d  = ST_DOWN;
                    drop_evt = 1'b1;
                end
            end
            default: state_d = ST_DOWN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DOWN;
            good_q    <= '0;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            link_up_q <= (state_d == ST_UP);
        end
    end

    assign link_up      = link_up_q;
    assign link_state   = state_q;
    assign local_fault  = lf_q;
    assign remote_fault = rf_q;

`ifdef XGMII_LINK_STATS_EN
    logic [15:0] err_q, err_d, drop_q, drop_d;

    always_comb begin
        err_d  = err_q;
        drop_d = drop_q;
        if (err_cyc && err_q != 16'hFFFF)   err_d  = err_q + 16'd1;
        if (drop_evt && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        if (stats_clear) begin
            err_d  = '0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            drop_q <= '0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign err_count  = err_q;
    assign drop_count = drop_q;
`else
    logic unused_stats;
    assign unused_stats = stats_clear ^ drop_evt;
    assign err_count    = '0;
    assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_xgmii_link_monitor.sv
// Bench for xgmii_link_monitor: table-driven column classification, hand-built link/fault sequences,
// and randomized traffic against a cycle-level model built from the link rules.
module tb_xgmii_link_monitor;

    localparam int UPC = 16;
    localparam int FWN = 64;
`ifdef XGMII_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_ready = 1'b0;
    logic        stats_clear = 1'b0;
    logic [71:0] dc;
    logic        link_up, local_fault, remote_fault;
    logic [1:0]  link_state;
    logic [15:0] err_count, drop_count;

    always #5 clk = ~clk;

    xgmii_link_monitor #(.UP_CYCLES(UPC), .FAULT_WINDOW(FWN)) dut (
        .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .xgmii_rx_dc(dc),
        .stats_clear(stats_clear), .link_up(link_up), .link_state(link_state),
        .local_fault(local_fault), .remote_fault(remote_fault),
        .err_count(err_count), .drop_count(drop_count)
    );

    localparam logic [35:0] IC   = {4{9'h107}};
    localparam logic [35:0] LFC  = {9'h001, 9'h000, 9'h000, 9'h19C};
    localparam logic [35:0] RFC  = {9'h002, 9'h000, 9'h000, 9'h19C};
    localparam logic [71:0] IDLE = {IC, IC};
    localparam logic [71:0] ERRW = {9'h107, 9'h107, 9'h1FE, 9'h107, IC};
    localparam logic [71:0] LFB  = {LFC, IC};
    localparam logic [71:0] RFB  = {RFC, IC};
    localparam logic [71:0] LFA  = {IC, LFC};

    typedef struct {
        logic [71:0] w;
        logic        lf;
        logic        rf;
        int          nerr;
    } vec_t;
    vec_t tbl[11];

    int checks = 0;
    int errors = 0;

    // Model state: plain integers, 0=DOWN 1=HOLD 2=UP, fault kind 0/1=LF/2=RF.
    int m_state, m_good, m_lf, m_rf, m_kind, m_cnt, m_gap, m_err, m_drop;
    logic [71:0] m_w;
    logic        m_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
        end
    endtask

    function automatic int col_kind(input logic [35:0] c);
        if (c[8:0] != 9'h19C || c[17:9] != 9'h000 || c[26:18] != 9'h000) return 0;
        if (c[35:27] == 9'h001) return 1;
        if (c[35:27] == 9'h002) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_good = 0; m_lf = 0; m_rf = 0; m_kind = 0;
        m_cnt = 0; m_gap = FWN; m_err = 0; m_drop = 0;
        m_w = IDLE; m_r = 1'b0;
    endtask

    task automatic model_step(input logic clr);
        int ka, kb, ft, flt;
        bit er;
        ka = col_kind(m_w[35:0]);
        kb = col_kind(m_w[71:36]);
        ft = (ka == 1 || kb == 1) ? 1 : ((ka == 2 || kb == 2) ? 2 : 0);
        er = 0;
        for (int i = 0; i < 8; i++) if (m_w[9*i +: 9] == 9'h1FE) er = 1;
        if (ft != 0) begin
            if (ft == m_kind && m_gap < FWN) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
            else begin m_kind = ft; m_cnt = 1; end
            m_gap = 0;
            if (m_cnt == 4) begin m_lf = (ft == 1); m_rf = (ft == 2); end
        end else if (m_gap < FWN) m_gap++;
        if (m_gap == FWN) begin m_lf = 0; m_rf = 0; end
        flt = m_lf | m_rf;
        if (m_state == 0) begin
            if (m_r && flt == 0) begin m_state = 1; m_good = 0; end
        end else if (m_state == 1) begin
            if (flt != 0 || !m_r) m_state = 0;
            else if (er || ft != 0) m_good = 0;
            else if (m_good == UPC) m_state = 2;
            else m_good++;
        end else begin
            if (flt != 0 || !m_r) begin
                m_state = 0;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (er && m_err < 65535) m_err++;
        if (clr) begin m_err = 0; m_drop = 0; end
    endtask

    task automatic compare_all();
        chk("link_state", link_state, m_state);
        chk("link_up", link_up, (m_state == 2));
        chk("local_fault", local_fault, m_lf);
        chk("remote_fault", remote_fault, m_rf);
        chk("err_count", err_count, STATS ? m_err : 0);
        chk("drop_count", drop_count, STATS ? m_drop : 0);
    endtask

    // Called just after a rising edge; the model advances with the DUT on the next edge.
    task automatic tick(input logic [71:0] w, input logic r, input logic c);
        dc = w; rx_ready = r; stats_clear = c;
        @(posedge clk);
        model_step(c);
        m_w = w; m_r = r;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [71:0] rand_word(input int d);
        logic [95:0] t;
        logic [71:0] w;
        int lane;
        if ($urandom_range(0, d - 1) != 0) return IDLE;
        w = IDLE;
        case ($urandom_range(0, 4))
            0: w = $urandom_range(0, 1) ? LFB : LFA;
            1: w = $urandom_range(0, 1) ? RFB : {IC, RFC};
            2: begin lane = $urandom_range(0, 7); w[9*lane +: 9] = 9'h1FE; end
            3: begin t = {$urandom, $urandom, $urandom}; w = t[71:0]; end
            default: w = {RFC, LFC};
        endcase
        return w;
    endfunction

    initial begin
        dc = IDLE;
        tbl[0]  = '{{IC, LFC},                                   1'b1, 1'b0, 0};
        tbl[1]  = '{RFB,                                         1'b0, 1'b1, 0};
        tbl[2]  = '{{RFC, LFC},                                  1'b1, 1'b0, 0};
        tbl[3]  = '{{LFC, RFC},                                  1'b1, 1'b0, 0};
        tbl[4]  = '{{IC, 9'h003, 9'h000, 9'h000, 9'h19C},        1'b0, 1'b0, 0};
        tbl[5]  = '{{9'h001, 9'h000, 9'h000, 9'h09C, IC},        1'b0, 1'b0, 0};
        tbl[6]  = '{{IC, 9'h001, 9'h000, 9'h001, 9'h19C},        1'b0, 1'b0, 0};
        tbl[7]  = '{{9'h101, 9'h000, 9'h000, 9'h19C, IC},        1'b0, 1'b0, 0};
        tbl[8]  = '{ERRW,                                        1'b0, 1'b0, 4};
        tbl[9]  = '{{IC, 9'h107, 9'h0FE, 9'h107, 9'h107},        1'b0, 1'b0, 0};
        tbl[10] = '{{RFC, RFC},                                  1'b0, 1'b1, 0};
        #1;
        do_reset();

        // Bring-up with continuous idle
        tick(IDLE, 1'b1, 1'b0);
        chk("bringup_edge1_down", link_state, 2'd0);
        tick(IDLE, 1'b1, 1'b0);
        chk("bringup_edge2_hold", link_state, 2'd1);
        repeat (UPC) tick(IDLE, 1'b1, 1'b0);
        chk("bringup_not_yet_up", link_up, 1'b0);
        tick(IDLE, 1'b1, 1'b0);
        chk("bringup_up", link_up, 1'b1);

        // Error character in HOLD at good_cnt=10, then in UP
        do_reset();
        repeat (11) tick(IDLE, 1'b1, 1'b0);
        tick(ERRW, 1'b1, 1'b0);
        tick(IDLE, 1'b1, 1'b0);
        chk("hold_err_count", err_count, STATS ? 16'd1 : 16'd0);
        repeat (16) tick(IDLE, 1'b1, 1'b0);
        chk("hold_restart_not_up", link_up, 1'b0);
        tick(IDLE, 1'b1, 1'b0);
        chk("hold_restart_up", link_up, 1'b1);
        tick(ERRW, 1'b1, 1'b0);
        tick(IDLE, 1'b1, 1'b0);
        chk("up_err_stays_up", link_state, 2'd2);
        chk("up_err_count", err_count, STATS ? 16'd2 : 16'd0);

        // Four LF sequences in column B, 10 cycles apart, while UP
        for (int k = 0; k < 4; k++) begin
            tick(LFB, 1'b1, 1'b0);
            if (k < 3) repeat (9) tick(IDLE, 1'b1, 1'b0);
        end
        tick(IDLE, 1'b1, 1'b0);
        chk("lf_flag_set", local_fault, 1'b1);
        chk("lf_state_down", link_state, 2'd0);
        chk("lf_drop_count", drop_count, STATS ? 16'd1 : 16'd0);
        repeat (63) tick(IDLE, 1'b1, 1'b0);
        chk("lf_still_set", local_fault, 1'b1);
        tick(IDLE, 1'b1, 1'b0);
        chk("lf_cleared", local_fault, 1'b0);
        chk("lf_clear_hold", link_state, 2'd1);

        // LF,LF,RF,RF,RF,RF at 5-cycle spacing
        for (int k = 0; k < 6; k++) begin
            tick((k < 2) ? LFB : RFB, 1'b1, 1'b0);
            if (k < 5) repeat (4) tick(IDLE, 1'b1, 1'b0);
        end
        tick(IDLE, 1'b1, 1'b0);
        chk("rf_flag_set", remote_fault, 1'b1);
        chk("rf_no_lf", local_fault, 1'b0);
        repeat (70) tick(IDLE, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick((k < 2) ? LFB : RFB, 1'b1, 1'b0);
            if (k < 4) repeat (4) tick(IDLE, 1'b1, 1'b0);
        end
        repeat (64) tick(IDLE, 1'b1, 1'b0);
        tick(RFB, 1'b1, 1'b0);
        tick(IDLE, 1'b1, 1'b0);
        chk("rf_gap_restart_rf", remote_fault, 1'b0);
        chk("rf_gap_restart_lf", local_fault, 1'b0);

        // Column classification table
        for (int i = 0; i < 11; i++) begin
            do_reset();
            repeat (4) tick(tbl[i].w, 1'b1, 1'b0);
            tick(IDLE, 1'b1, 1'b0);
            chk("tbl_local_fault", local_fault, tbl[i].lf);
            chk("tbl_remote_fault", remote_fault, tbl[i].rf);
            chk("tbl_err_count", err_count, STATS ? tbl[i].nerr : 0);
        end

        // Randomized traffic in bursts of varying density, with a mid-run reset
        do_reset();
        for (int b = 0; b < 60; b++) begin
            int d;
            d = $urandom_range(2, 40);
            for (int k = 0; k < 30; k++)
                tick(rand_word(d), ($urandom_range(0, 31) != 0), ($urandom_range(0, 63) == 0));
            if (b == 30) do_reset();
        end

        // err_count saturation and clear-wins
        do_reset();
        repeat (65536) tick(ERRW, 1'b1, 1'b0);
        chk("err_preload", err_count, STATS ? 16'hFFFF : 16'd0);
        repeat (3) tick(ERRW, 1'b1, 1'b0);
        chk("err_saturated", err_count, STATS ? 16'hFFFF : 16'd0);
        tick(ERRW, 1'b1, 1'b1);
        chk("err_clear_wins", err_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
